// File: rtl/lp_result_collector.sv
// lp_result_collector: deskews LANES systolic down-streams in per-lane FIFOs and merges aligned words into one wide AXI-Stream beat.
// Define LP_COLLECT_TUSER_CHECK_EN to keep every lane's tuser and flag cross-lane tuser disagreement.
module lp_result_collector #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*DATA_WIDTH-1:0] s_axis_down_tdata,
    input  logic [LANES-1:0]            s_axis_down_tvalid,
    output logic [LANES-1:0]            s_axis_down_tready,
    input  logic [LANES-1:0]            s_axis_down_tlast,
    input  logic [LANES*ID_WIDTH-1:0]   s_axis_down_tid,
    input  logic [LANES*DEST_WIDTH-1:0] s_axis_down_tdest,
    input  logic [LANES*USER_WIDTH-1:0] s_axis_down_tuser,
    output logic [LANES*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [ID_WIDTH-1:0]         m_axis_tid,
    output logic [DEST_WIDTH-1:0]       m_axis_tdest,
    output logic [USER_WIDTH-1:0]       m_axis_tuser,
    output logic                        err_unaligned_data,
    output logic                        err_user_flag
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef LP_COLLECT_TUSER_CHECK_EN
    localparam int UL = LANES;
`else
    localparam int UL = 1;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_RESYNC} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0] mem_data [LANES][FIFO_DEPTH];
    logic                  mem_last [LANES][FIFO_DEPTH];
    logic [USER_WIDTH-1:0] mem_user [UL][FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   mem_id   [FIFO_DEPTH];
    logic [DEST_WIDTH-1:0] mem_dest [FIFO_DEPTH];
    logic [AW:0]           wr_ptr   [LANES];
    logic [AW:0]           rd_ptr   [LANES];

    logic [LANES-1:0]            empty, full, push, pop, drop, head_last, need, need_next;
    logic [LANES*DATA_WIDTH-1:0] head_data;
    logic                        load, mixed, unused_lanes;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            empty[i] = wr_ptr[i] == rd_ptr[i];
            full[i] = wr_ptr[i] == {~rd_ptr[i][AW], rd_ptr[i][AW-1:0]};
            head_last[i] = mem_last[i][rd_ptr[i][AW-1:0]];
            head_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_data[i][rd_ptr[i][AW-1:0]];
        end
    end

    assign s_axis_down_tready = {LANES{rst_n}} & ~full;
    assign push      = s_axis_down_tvalid & s_axis_down_tready;
    assign load      = state != ST_RESYNC && empty == '0 && (!m_axis_tvalid || m_axis_tready);
    assign mixed     = |head_last && !(&head_last);
    // while resyncing, lanes still owing a tlast word discard one word per clock
    assign drop      = state == ST_RESYNC ? need & ~empty : '0;
    assign pop       = {LANES{load}} | drop;
    assign need_next = need & ~(drop & head_last);

    // tid/tdest (and tuser without the checker) beyond lane 0 are never forwarded
`ifdef LP_COLLECT_TUSER_CHECK_EN
    assign unused_lanes = ^{s_axis_down_tid[LANES*ID_WIDTH-1:ID_WIDTH],
                            s_axis_down_tdest[LANES*DEST_WIDTH-1:DEST_WIDTH]};
`else
    assign unused_lanes = ^{s_axis_down_tid[LANES*ID_WIDTH-1:ID_WIDTH],
                            s_axis_down_tdest[LANES*DEST_WIDTH-1:DEST_WIDTH],
                            s_axis_down_tuser[LANES*USER_WIDTH-1:USER_WIDTH]};
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push[i]) begin
                mem_data[i][wr_ptr[i][AW-1:0]] <= s_axis_down_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                mem_last[i][wr_ptr[i][AW-1:0]] <= s_axis_down_tlast[i];
            end
        end
        for (int i = 0; i < UL; i++) begin
            if (push[i]) mem_user[i][wr_ptr[i][AW-1:0]] <= s_axis_down_tuser[i*USER_WIDTH +: USER_WIDTH];
        end
        if (push[0]) begin
            mem_id[wr_ptr[0][AW-1:0]] <= s_axis_down_tid[ID_WIDTH-1:0];
            mem_dest[wr_ptr[0][AW-1:0]] <= s_axis_down_tdest[DEST_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

`ifdef LP_COLLECT_TUSER_CHECK_EN
    logic user_diff;
    always_comb begin
        user_diff = 1'b0;
        for (int i = 1; i < LANES; i++)
            user_diff = user_diff | (mem_user[i][rd_ptr[i][AW-1:0]] != mem_user[0][rd_ptr[0][AW-1:0]]);
    end
`else
    assign err_user_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            need <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
            m_axis_tid <= '0;
            m_axis_tdest <= '0;
            m_axis_tuser <= '0;
            err_unaligned_data <= 1'b0;
`ifdef LP_COLLECT_TUSER_CHECK_EN
            err_user_flag <= 1'b0;
`endif
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata <= head_data;
            m_axis_tlast <= mixed | head_last[0];
            m_axis_tid <= mem_id[rd_ptr[0][AW-1:0]];
            m_axis_tdest <= mem_dest[rd_ptr[0][AW-1:0]];
            m_axis_tuser <= mem_user[0][rd_ptr[0][AW-1:0]];
            state <= mixed ? ST_RESYNC : head_last[0] ? ST_IDLE : ST_PKT;
            need <= mixed ? ~head_last : '0;
            err_unaligned_data <= err_unaligned_data | mixed;
`ifdef LP_COLLECT_TUSER_CHECK_EN
            err_user_flag <= err_user_flag | user_diff;
`endif
        end else begin
            if (m_axis_tready) m_axis_tvalid <= 1'b0;
            if (state == ST_RESYNC) begin
                need <= need_next;
                if (need_next == '0) state <= ST_IDLE;
            end
        end
    end
endmodule
